// File: rtl/divide_sequencer.sv
// divide_sequencer: hands one operand pair at a time to an external
// multi-cycle divider (start pulse, NBITS iterations, stop pulse), captures
// its result and presents it with a valid/ready handshake. Divide-by-zero
// is resolved locally without touching the divider.
module divide_sequencer #(
  parameter int NBITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_dividend,
  input  logic [NBITS-1:0] in_divisor,
  output logic             div_start,
  output logic             div_stop,
  output logic [NBITS-1:0] div_dividend,
  output logic [NBITS-1:0] div_divisor,
  input  logic [NBITS-1:0] div_quotient,
  input  logic [NBITS-1:0] div_rest,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_quotient,
  output logic [NBITS-1:0] out_rest,
  output logic             out_dz,
  output logic             busy
);

  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    STOP  = 3'd3,
    CAPT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             div_start_r, div_start_nxt_s;
  logic             div_stop_r, div_stop_nxt_s;
  logic [NBITS-1:0] dividend_r, dividend_nxt_s;
  logic [NBITS-1:0] divisor_r, divisor_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic [NBITS-1:0] quot_r, quot_nxt_s;
  logic [NBITS-1:0] rest_r, rest_nxt_s;
  logic             dz_r, dz_nxt_s;

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    div_start_nxt_s = 1'b0;
    div_stop_nxt_s  = 1'b0;
    dividend_nxt_s  = dividend_r;
    divisor_nxt_s   = divisor_r;
    out_valid_nxt_s = out_valid_r;
    quot_nxt_s      = quot_r;
    rest_nxt_s      = rest_r;
    dz_nxt_s        = dz_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (in_divisor != {NBITS{1'b0}}) begin
            // start pulse is registered here so it is high exactly during START
            dividend_nxt_s  = in_dividend;
            divisor_nxt_s   = in_divisor;
            div_start_nxt_s = 1'b1;
            state_nxt_s     = START;
          end else begin
            quot_nxt_s      = {NBITS{1'b1}};
            rest_nxt_s      = in_dividend;
            dz_nxt_s        = 1'b1;
            out_valid_nxt_s = 1'b1;
            state_nxt_s     = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = RUN;
      end
      RUN: begin
        cnt_nxt_s = cnt_r + CW'(1);
        if (cnt_r == CW'(NBITS - 1)) begin
          // stop pulse is registered here so it is high exactly during STOP
          div_stop_nxt_s = 1'b1;
          state_nxt_s    = STOP;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STOP: begin
        state_nxt_s = CAPT;
      end
      CAPT: begin
        quot_nxt_s      = div_quotient;
        rest_nxt_s      = div_rest;
        dz_nxt_s        = 1'b0;
        out_valid_nxt_s = 1'b1;
        state_nxt_s     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Iteration counter, divider operands/pulses and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r       <= {CW{1'b0}};
      div_start_r <= 1'b0;
      div_stop_r  <= 1'b0;
      dividend_r  <= {NBITS{1'b0}};
      divisor_r   <= {NBITS{1'b0}};
      out_valid_r <= 1'b0;
      quot_r      <= {NBITS{1'b0}};
      rest_r      <= {NBITS{1'b0}};
      dz_r        <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      div_start_r <= div_start_nxt_s;
      div_stop_r  <= div_stop_nxt_s;
      dividend_r  <= dividend_nxt_s;
      divisor_r   <= divisor_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      quot_r      <= quot_nxt_s;
      rest_r      <= rest_nxt_s;
      dz_r        <= dz_nxt_s;
    end
  end

  // in_ready is gated by reset so it drops the moment reset asserts.
  assign in_ready     = (state_r == IDLE) && reset;
  assign busy         = (state_r != IDLE);
  assign div_start    = div_start_r;
  assign div_stop     = div_stop_r;
  assign div_dividend = dividend_r;
  assign div_divisor  = divisor_r;
  assign out_valid    = out_valid_r;
  assign out_quotient = quot_r;
  assign out_rest     = rest_r;
  assign out_dz       = dz_r;

endmodule

// File: tb/tb_divide_sequencer.sv
// Bench for divide_sequencer: behavioural divider, pulse monitor and a
// scoreboard of expected results pushed when each operand pair is offered.
module tb_divide_sequencer;

  localparam int NBITS = 32;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NBITS-1:0]  in_dividend = '0;
  logic [NBITS-1:0]  in_divisor = '0;
  logic              div_start, div_stop;
  logic [NBITS-1:0]  div_dividend, div_divisor;
  logic [NBITS-1:0]  div_quotient, div_rest;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NBITS-1:0]  out_quotient, out_rest;
  logic              out_dz, busy;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // pulse monitor state
  int start_pulses = 0, stop_pulses = 0, bad_w = 0, bad_gap = 0;
  int overlap_cnt = 0, opchg_cnt = 0;
  int sw = 0, pw = 0, gapc = 0;
  bit gapping = 1'b0, in_op = 1'b0, end_op = 1'b0;
  logic [NBITS-1:0] op_a, op_b;

  divide_sequencer #(.NBITS(NBITS)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_stop(div_stop),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_rest(div_rest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_rest(out_rest),
    .out_dz(out_dz), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural divider: results appear only when the stop pulse is seen;
  // a start pulse poisons the outputs so early capture is visible.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_quotient <= '0;
      div_rest     <= '0;
    end else if (div_stop) begin
      if (div_divisor != 0) begin
        div_quotient <= div_dividend / div_divisor;
        div_rest     <= div_dividend % div_divisor;
      end else begin
        div_quotient <= '1;
        div_rest     <= div_dividend;
      end
    end else if (div_start) begin
      div_quotient <= 32'hDEAD_BEEF;
      div_rest     <= 32'hBAD0_BAD0;
    end
  end

  // Pulse monitor: widths, start-to-stop gap, overlap, operand stability.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        sw = 0; pw = 0; gapping = 1'b0; in_op = 1'b0;
      end else begin
        end_op = 1'b0;
        if (div_start && div_stop) overlap_cnt++;
        if (div_start) begin
          if (sw == 0) begin
            start_pulses++; op_a = div_dividend; op_b = div_divisor; in_op = 1'b1;
          end
          sw++; gapping = 1'b0;
        end else if (sw != 0) begin
          if (sw != 1) bad_w++;
          sw = 0; gapping = 1'b1; gapc = 0;
        end
        if (gapping && !div_start && !div_stop) gapc++;
        if (div_stop) begin
          if (pw == 0) begin
            stop_pulses++;
            if (!gapping || gapc != NBITS) bad_gap++;
            gapping = 1'b0;
          end
          pw++;
        end else if (pw != 0) begin
          if (pw != 1) bad_w++;
          pw = 0; end_op = 1'b1;
        end
        if (in_op && (div_dividend !== op_a || div_divisor !== op_b)) opchg_cnt++;
        if (end_op) in_op = 1'b0;
      end
    end
  end

  // Offer a pair (called at a negedge); returns at the negedge after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int guard;
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_dividend = $urandom;
    in_divisor = $urandom;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = NBITS + 4;
    end
    sb.push_back(e);
  endtask

  // Count edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [163:0] all_s;
    #3;
    all_s = {div_start, div_stop, div_dividend, div_divisor, out_valid,
             out_quotient, out_rest, out_dz, busy, in_ready};
    n_checks++;
    if (all_s !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_s);
    end
    in_valid = 1'b1; in_dividend = 32'd9; in_divisor = 32'd3;
    repeat (3) @(negedge clock);
    all_s = {div_start, div_stop, div_dividend, div_divisor, out_valid,
             out_quotient, out_rest, out_dz, busy, in_ready};
    n_checks++;
    if (all_s !== '0) begin
      n_fail++; $display("FAIL reset_held_inputs: got %h expected 0", all_s);
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_nominal();
    exp_t e;
    int lat, s0, p0;
    s0 = start_pulses; p0 = stop_pulses;
    out_ready = 1'b1;
    send(32'd123456, 32'd789);
    wait_valid(lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat) begin
      n_fail++; $display("FAIL nominal_latency: got %0d expected %0d", lat, e.lat);
    end
    n_checks++;
    if (out_quotient !== 32'd156 || out_rest !== 32'd372 || out_dz !== 1'b0 ||
        out_quotient !== e.q || out_rest !== e.r) begin
      n_fail++; $display("FAIL nominal_result: got q=%0d r=%0d dz=%b expected q=156 r=372 dz=0",
                         out_quotient, out_rest, out_dz);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL nominal_done_ready: got in_ready=%b expected 0", in_ready);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL nominal_idle: busy=%b out_valid=%b expected 0/0", busy, out_valid);
    end
    n_checks++;
    if (start_pulses - s0 != 1 || stop_pulses - p0 != 1) begin
      n_fail++; $display("FAIL nominal_pulses: start=%0d stop=%0d expected 1/1",
                         start_pulses - s0, stop_pulses - p0);
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    int lat, s0, p0;
    s0 = start_pulses; p0 = stop_pulses;
    out_ready = 1'b1;
    send(32'd100, 32'd0);
    wait_valid(lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat) begin
      n_fail++; $display("FAIL dz_latency: got %0d expected %0d", lat, e.lat);
    end
    n_checks++;
    if (out_quotient !== e.q || out_rest !== e.r || out_dz !== e.dz) begin
      n_fail++; $display("FAIL dz_result: got q=%h r=%0d dz=%b expected q=%h r=%0d dz=%b",
                         out_quotient, out_rest, out_dz, e.q, e.r, e.dz);
    end
    @(negedge clock);
    n_checks++;
    if (start_pulses != s0 || stop_pulses != p0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dz_no_pulse: start=%0d stop=%0d busy=%b expected 0/0/0",
                         start_pulses - s0, stop_pulses - p0, busy);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat, bad;
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'd1);
    wait_valid(lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || out_quotient !== 32'hFFFF_FFFF || out_rest !== 32'd0 || out_dz !== 1'b0) begin
      n_fail++; $display("FAIL bp_result: got lat=%0d q=%h r=%0d dz=%b expected lat=%0d q=ffffffff r=0 dz=0",
                         lat, out_quotient, out_rest, out_dz, e.lat);
    end
    in_valid = 1'b1; in_dividend = 32'd7; in_divisor = 32'd3;
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid !== 1'b1 || out_quotient !== e.q || out_rest !== e.r ||
          out_dz !== e.dz || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: busy=%b out_valid=%b in_ready=%b expected 0/0/1",
                         busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int lat, p0;
    logic [163:0] all_s;
    out_ready = 1'b1;
    p0 = stop_pulses;
    send(32'd5555, 32'd3);
    sb.delete();
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    all_s = {div_start, div_stop, div_dividend, div_divisor, out_valid,
             out_quotient, out_rest, out_dz, busy, in_ready};
    n_checks++;
    if (all_s !== '0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: got %h expected 0", all_s);
    end
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    repeat (40) @(negedge clock);
    n_checks++;
    if (stop_pulses != p0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_abort: stop=%0d out_valid=%b busy=%b expected 0/0/0",
                         stop_pulses - p0, out_valid, busy);
    end
    send(32'd1000, 32'd7);
    wait_valid(lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || out_quotient !== 32'd142 || out_rest !== 32'd6 || out_dz !== 1'b0) begin
      n_fail++; $display("FAIL midrun_fresh: got lat=%0d q=%0d r=%0d dz=%b expected lat=%0d q=142 r=6 dz=0",
                         lat, out_quotient, out_rest, out_dz, e.lat);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat, s0, p0, bw0, bg0, oc0, ov0, nz;
    logic [31:0] a, b;
    s0 = start_pulses; p0 = stop_pulses; bw0 = bad_w; bg0 = bad_gap;
    oc0 = opchg_cnt; ov0 = overlap_cnt; nz = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin a = 32'd1000;       b = 32'd7;  end
        1: begin a = 32'hFFFF_FFFF;  b = 32'h10; end
        2: begin a = 32'd5;          b = 32'd9;  end
        3: begin a = 32'd77;         b = 32'd0;  end
        4: begin a = 32'h8000_0000;  b = 32'hFFFF_FFFF; end
        default: begin a = $urandom; b = $urandom_range(1, 65535); end
      endcase
      if (b != 0) nz++;
      send(a, b);
      wait_valid(lat);
      e = sb.pop_front();
      n_checks++;
      if (lat !== e.lat || out_quotient !== e.q || out_rest !== e.r || out_dz !== e.dz) begin
        n_fail++; $display("FAIL b2b_op%0d: got lat=%0d q=%h r=%h dz=%b expected lat=%0d q=%h r=%h dz=%b",
                           i, lat, out_quotient, out_rest, out_dz, e.lat, e.q, e.r, e.dz);
      end
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    n_checks++;
    if (start_pulses - s0 != nz || stop_pulses - p0 != nz) begin
      n_fail++; $display("FAIL b2b_pulse_count: start=%0d stop=%0d expected %0d",
                         start_pulses - s0, stop_pulses - p0, nz);
    end
    n_checks++;
    if (bad_w != bw0 || bad_gap != bg0 || overlap_cnt != ov0) begin
      n_fail++; $display("FAIL b2b_pulse_shape: bad_width=%0d bad_gap=%0d overlap=%0d expected 0/0/0",
                         bad_w - bw0, bad_gap - bg0, overlap_cnt - ov0);
    end
    n_checks++;
    if (opchg_cnt != oc0) begin
      n_fail++; $display("FAIL b2b_operand_stable: got %0d changes expected 0", opchg_cnt - oc0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
